// File: rtl/pio_pkg.sv
// Shared definitions for the PIO block and its configuration sequencer:
// action codes presented on the PIO action port and the sequencer states.
package pio_pkg;

    // PIO action codes
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_RST   = 4'd3;
    localparam logic [3:0] ACT_IMM   = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_PUSH  = 4'd8;
    localparam logic [3:0] ACT_PULL  = 4'd9;
    localparam logic [3:0] ACT_PINS  = 4'd10;
    localparam logic [3:0] ACT_DIRS  = 4'd11;
    localparam logic [3:0] ACT_IDIRS = 4'd12;

    // Instruction memory address width
    localparam int PROG_AW = 5;

    // Configuration sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PEND  = 3'd3,
        ST_DIV   = 3'd4,
        ST_GRPS  = 3'd5,
        ST_EN    = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_t;

endpackage

// File: rtl/pio_cfg_seq_if.sv
// PIO action port: one action code plus its instruction index, machine
// index and data word. The sequencer drives it, the PIO consumes it.
interface pio_cfg_seq_if;
    import pio_pkg::*;

    logic [3:0]         action;
    logic [PROG_AW-1:0] index;
    logic [1:0]         mindex;
    logic [31:0]        din;

    modport master (output action, output index, output mindex, output din);
    modport slave  (input  action, input  index, input  mindex, input  din);

endinterface

// File: rtl/pio_cfg_seq.sv
// Configuration sequencer for one PIO instance. On start it latches the
// configuration, streams plen instructions from an external synchronous ROM
// into the PIO, then issues PEND, DIV, GRPS and optionally EN actions for
// the selected state machine. abort returns to IDLE at any point.
module pio_cfg_seq
    import pio_pkg::*;
#(
    parameter int PROG_DEPTH = 32,
    parameter int ROM_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           cfg_mindex,
    input  logic [5:0]           cfg_plen,
    input  logic [31:0]          cfg_exec,
    input  logic [23:0]          cfg_div,
    input  logic [31:0]          cfg_grps,
    input  logic                 cfg_en,
    output logic [PROG_AW-1:0]   prog_addr,
    input  logic [15:0]          prog_data,
    pio_cfg_seq_if.master        pio,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam logic [5:0] PLEN_MAX = 6'(PROG_DEPTH);

    seq_state_t         state_q, state_d;

    // Shadow copies of the configuration, captured on start
    logic [5:0]         plen_q, plen_d;
    logic [31:0]        exec_q, exec_d;
    logic [23:0]        div_q, div_d;
    logic [31:0]        grps_q, grps_d;
    logic               en_q, en_d;

    // Registered outputs
    logic [3:0]         action_q, action_d;
    logic [PROG_AW-1:0] index_q, index_d;
    logic [1:0]         mindex_q, mindex_d;
    logic [31:0]        din_q, din_d;
    logic [PROG_AW-1:0] prog_addr_q, prog_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic [5:0]         plen_clamped;

    assign plen_clamped = (cfg_plen > PLEN_MAX) ? PLEN_MAX : cfg_plen;

    // Next state, shadow capture, then output decode of the state being entered
    always_comb begin
        state_d     = state_q;
        plen_d      = plen_q;
        exec_d      = exec_q;
        div_d       = div_q;
        grps_d      = grps_q;
        en_d        = en_q;
        mindex_d    = mindex_q;
        index_d     = index_q;
        prog_addr_d = prog_addr_q;
        action_d    = ACT_NONE;
        din_d       = 32'h0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    plen_d   = plen_clamped;
                    exec_d   = cfg_exec;
                    div_d    = cfg_div;
                    grps_d   = cfg_grps;
                    en_d     = cfg_en;
                    mindex_d = cfg_mindex;
                    index_d  = '0;
                    state_d  = (plen_clamped == 6'd0) ? ST_PEND : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // index counts ROM priming cycles here; LOAD restarts it at 0
                if (int'(index_q) >= ROM_LAT - 1) begin
                    state_d = ST_LOAD;
                    index_d = '0;
                end else begin
                    index_d = index_q + 5'd1;
                end
            end
            ST_LOAD: begin
                if ({1'b0, index_q} == plen_q - 6'd1) begin
                    state_d = ST_PEND;
                end else begin
                    index_d = index_q + 5'd1;
                end
            end
            ST_PEND: state_d = ST_DIV;
            ST_DIV:  state_d = ST_GRPS;
            ST_GRPS: state_d = en_q ? ST_EN : ST_DONE;
            ST_EN:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && abort) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end

        case (state_d)
            ST_FETCH: begin
                busy_d      = 1'b1;
                prog_addr_d = '0;
            end
            ST_LOAD: begin
                // Address for the next beat goes out with the current beat
                action_d    = ACT_INSTR;
                busy_d      = 1'b1;
                prog_addr_d = index_d + 5'd1;
            end
            ST_PEND: begin
                action_d = ACT_PEND;
                din_d    = exec_d;
                busy_d   = 1'b1;
            end
            ST_DIV: begin
                action_d = ACT_DIV;
                din_d    = {8'h0, div_d};
                busy_d   = 1'b1;
            end
            ST_GRPS: begin
                action_d = ACT_GRPS;
                din_d    = grps_d;
                busy_d   = 1'b1;
            end
            ST_EN: begin
                action_d = ACT_EN;
                din_d    = 32'h1 << mindex_d;
                busy_d   = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, shadow and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            plen_q      <= '0;
            exec_q      <= '0;
            div_q       <= '0;
            grps_q      <= '0;
            en_q        <= 1'b0;
            action_q    <= ACT_NONE;
            index_q     <= '0;
            mindex_q    <= '0;
            din_q       <= '0;
            prog_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            plen_q      <= plen_d;
            exec_q      <= exec_d;
            div_q       <= div_d;
            grps_q      <= grps_d;
            en_q        <= en_d;
            action_q    <= action_d;
            index_q     <= index_d;
            mindex_q    <= mindex_d;
            din_q       <= din_d;
            prog_addr_q <= prog_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // During LOAD the instruction word comes straight from the ROM output register
    assign pio.din    = (state_q == ST_LOAD) ? {16'h0, prog_data} : din_q;
    assign pio.action = action_q;
    assign pio.index  = index_q;
    assign pio.mindex = mindex_q;
    assign prog_addr  = prog_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: doc/pio_cfg_seq.md
# pio_cfg_seq

Configuration sequencer for one `pio` instance. On a `start` pulse it streams a program from a synchronous instruction ROM into the PIO through the PIO action port (`action`/`index`/`mindex`/`din`). It then writes exec control, clock divider and pin groups for the selected state machine, and optionally enables it. It sits between the system bring-up logic and `pio`, and replaces the hand-sequenced action writes used during bring-up.

## Interface
Parameters:
- `PROG_DEPTH`, 32: instruction memory depth; index width is 5.
- `ROM_LAT`, 1: ROM read latency in cycles; only 1 is supported.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `abort`  in  1  cancel the current sequence.
- `cfg_mindex`  in  2  target state machine.
- `cfg_plen`  in  6  program length, 0..32; values above 32 are clamped to 32.
- `cfg_exec`  in  32  exec-control word (PEND action).
- `cfg_div`  in  24  clock divider (DIV action).
- `cfg_grps`  in  32  pin-group word (GRPS action).
- `cfg_en`  in  1  issue an EN action at the end of the sequence.
- `prog_addr`  out  5  ROM address.
- `prog_data`  in  16  ROM data, valid 1 cycle after `prog_addr`.
- `action`  out  4  PIO action code.
- `index`  out  5  PIO instruction index.
- `mindex`  out  2  PIO machine index.
- `din`  out  32  PIO data.
- `busy`  out  1  sequence in progress.
- `done`  out  1  1-cycle pulse on normal completion.
- `aborted`  out  1  1-cycle pulse on abort.

## Operation
- States: IDLE, FETCH, LOAD, PEND, DIV, GRPS, EN, DONE.
- IDLE: `start` latches all `cfg_*` inputs into shadow registers. Next state is FETCH, or PEND when plen=0. Later changes to `cfg_*` have no effect until the next start.
- FETCH: `prog_addr`=0, `action`=NONE. Next state is LOAD.
- LOAD, beat i (0..plen-1): `action`=INSTR, `index`=i, `din`={16'h0,`prog_data`}. On the same beat `prog_addr`=i+1, pipelined. After beat plen-1 the next state is PEND.
- PEND: `din`=exec. DIV: `din`={8'h0,div}. GRPS: `din`=grps.
- EN, only when the en shadow bit is 1: `din`=32'h1<<mindex. When the bit is 0, GRPS goes directly to DONE.
- DONE: `action`=NONE, `done`=1. Next state is IDLE.
- `mindex` holds the latched value from FETCH through EN.
- `start` while busy is ignored.
- `abort` in any non-IDLE state:
  - next cycle: state IDLE, `action`=NONE, `aborted`=1, no `done`;
  - a partially loaded program stays in the PIO as written.
- `abort` in IDLE is ignored.
- `abort` and `start` together in IDLE: `start` wins.
- Action codes: NONE=0, INSTR=1, PEND=2, DIV=7, GRPS=5, EN=6.

## Timing
- All outputs are registered. Each action is presented for exactly one clock, so the PIO samples it at the following posedge.
- Reset values: state IDLE; `action` 0, `index` 0, `mindex` 0, `din` 0, `prog_addr` 0, `busy` 0, `done` 0, `aborted` 0; shadow registers 0.
- `start` is sampled at edge 0. FETCH occupies cycle 1 and the INSTR beats occupy cycles 2..plen+1. PEND, DIV, GRPS and EN each take one cycle after that. DONE follows, so with EN total latency is plen+6 cycles (plen+5 without EN).
- `busy` is 1 from FETCH (or PEND when plen=0) through the last action cycle, and 0 in DONE.
- `prog_addr` on the final LOAD beat is plen, masked to 5 bits, so plen=32 wraps to 0. The ROM data returned for it is unused.
- `reset_n` mid-sequence: all outputs immediately (asynchronously) take their reset values. No `done` or `aborted` pulse is produced.

## Structure
- Package `pio_pkg`:
  - action-code localparams (NONE..IDIRS, 0..12) shared with `pio` and the benches;
  - state enum.
- Single flat module. No sub-module is warranted; the ROM is external.

## Test plan
- Square-wave config: plen=2, ROM={E081,E001}, exec=0x00001000, div=0x000280, grps=0x04000000, en=1, mindex=0.
  - Required: INSTR idx0 din=0xE081, INSTR idx1 din=0xE001, PEND 0x1000, DIV 0x280, GRPS 0x04000000, EN 0x1, then `done` at cycle 8.
- plen=0, en=0, mindex=3: FETCH skipped; sequence is PEND, DIV, GRPS with `mindex`=3 throughout, then `done` at cycle 4; no INSTR is issued.
- plen=40 (clamped to 32), ROM[i]=i: 32 INSTR beats with `index` 0..31 and `din`=i, `prog_addr` wraps to 0 on the last beat, then `done` at cycle 38.
- `start` pulsed during LOAD with different `cfg_div`: no restart; DIV still carries the value latched at the original start.
- `abort` on INSTR beat 1 of a 4-instruction load: next cycle `action`=NONE and `aborted`=1, no `done`; `busy` stays 0 afterwards.
- `reset_n` low during DIV: `action`/`din`/`busy` are 0 before the next clock edge. After release, a new `start` runs a full, correct sequence.
